// File: rtl/audio_tone_gen.sv
// Multi-channel phase-accumulator test-tone source with an AXI-stream frame output.
// Square, sawtooth, triangle or silence; per-channel invert, enable and shared attenuation.
module audio_tone_gen #(
  parameter int unsigned SAMPLE_WIDTH = 24,
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned PHASE_WIDTH  = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [1:0]                       mode,
  input  logic [PHASE_WIDTH-1:0]           phase_inc,
  input  logic [$clog2(SAMPLE_WIDTH)-1:0]  atten,
  input  logic [CHANNELS-1:0]              ch_enable,
  input  logic [CHANNELS-1:0]              ch_invert,
  input  logic                             phase_clear,
  output logic [CHANNELS*SAMPLE_WIDTH-1:0] m_data,
  output logic                             m_valid,
  input  logic                             m_ready
);

  localparam int unsigned AttenWidth = $clog2(SAMPLE_WIDTH);

  localparam logic signed [SAMPLE_WIDTH-1:0] MaxVal = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
  localparam logic signed [SAMPLE_WIDTH-1:0] MinVal = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
  localparam logic [AttenWidth:0]            AttenMax = (AttenWidth+1)'(SAMPLE_WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StValid} state_e;
  typedef enum logic [1:0] {ModeSilence, ModeSquare, ModeSaw, ModeTri} mode_e;

  state_e                           state_q, state_d;
  logic [PHASE_WIDTH-1:0]           phase_q, phase_d;
  logic [PHASE_WIDTH-1:0]           inc_q, inc_d;
  logic [CHANNELS*SAMPLE_WIDTH-1:0] data_q, data_d;
  logic [CHANNELS*SAMPLE_WIDTH-1:0] frame;
  logic [PHASE_WIDTH-1:0]           phase_sel;
  logic [SAMPLE_WIDTH:0]            p;
  logic                             half;
  logic [SAMPLE_WIDTH-1:0]          t;
  logic [SAMPLE_WIDTH-1:0]          u;
  logic [SAMPLE_WIDTH-1:0]          wave;
  logic signed [SAMPLE_WIDTH-1:0]   wave_s;
  logic [AttenWidth-1:0]            shamt;
  logic                             compute;

  // Phase of the frame that would be computed this cycle: in VALID it is the
  // advanced phase (used only on a handshake), in IDLE the stored phase.
  always_comb begin
    phase_sel = (state_q == StValid) ? phase_q + inc_q : phase_q;
    if (phase_clear) begin
      phase_sel = '0;
    end
    p    = phase_sel[PHASE_WIDTH-1 -: SAMPLE_WIDTH+1];
    half = p[SAMPLE_WIDTH];
    t    = p[SAMPLE_WIDTH-1:0];
    u    = half ? ~t : t;
    wave = '0;
    unique case (mode_e'(mode))
      ModeSilence: wave = '0;
      ModeSquare:  wave = half ? MinVal : MaxVal;
      ModeSaw:     wave = {~half, t[SAMPLE_WIDTH-1:1]};
      ModeTri:     wave = {~u[SAMPLE_WIDTH-1], u[SAMPLE_WIDTH-2:0]};
    endcase
  end

  assign wave_s = $signed(wave);
  assign shamt  = ({1'b0, atten} > AttenMax) ? AttenMax[AttenWidth-1:0] : atten;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic signed [SAMPLE_WIDTH-1:0] inv_s;
    logic signed [SAMPLE_WIDTH-1:0] shr_s;

    // Negating the most negative value would overflow; saturate instead.
    always_comb begin
      inv_s = wave_s;
      if (ch_invert[c]) begin
        inv_s = (wave_s == MinVal) ? MaxVal : -wave_s;
      end
    end

    assign shr_s = inv_s >>> shamt;
    assign frame[(CHANNELS-1-c)*SAMPLE_WIDTH +: SAMPLE_WIDTH] = ch_enable[c] ? shr_s : '0;
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    inc_d   = inc_q;
    data_d  = data_q;
    compute = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable) begin
          compute = 1'b1;
          state_d = StValid;
        end
      end
      StValid: begin
        if (m_ready) begin
          phase_d = phase_sel;
          if (enable) begin
            compute = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
    endcase
    // The step is latched with the frame so a stalled frame advances consistently.
    if (compute) begin
      phase_d = phase_sel;
      inc_d   = phase_inc;
      data_d  = frame;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      phase_q <= '0;
      inc_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      inc_q   <= inc_d;
      data_q  <= data_d;
    end
  end

  assign m_valid = (state_q == StValid);
  assign m_data  = data_q;

endmodule
